// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter letting two write requesters share one DEPTH x WIDTH
// register bank. The bank has a single combinational read port and a commit counter.
module reg_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             ReqA,
  input  logic [AW-1:0]    AddrA,
  input  logic [WIDTH-1:0] DataA,
  output logic             GntA,
  input  logic             ReqB,
  input  logic [AW-1:0]    AddrB,
  input  logic [WIDTH-1:0] DataB,
  output logic             GntB,
  input  logic [AW-1:0]    RdAddr,
  output logic [WIDTH-1:0] RdData,
  output logic [7:0]       WrCount
);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  req_e             last, last_next;
  logic             elig_a, elig_b;
  logic             grant_a, grant_b;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] bank [DEPTH];

  // A requester is ignored while its own grant pulse is showing.
  assign elig_a = ReqA & ~GntA;
  assign elig_b = ReqB & ~GntB;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    last_next = last;
    wr_addr   = AddrA;
    wr_data   = DataA;
    if (elig_a && (!elig_b || last == REQ_B)) begin
      grant_a   = 1'b1;
      last_next = REQ_A;
    end else if (elig_b) begin
      grant_b   = 1'b1;
      last_next = REQ_B;
      wr_addr   = AddrB;
      wr_data   = DataB;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the bank is small and must read as zero after reset, so it is
  // built from resettable flops rather than a RAM macro.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      last    <= REQ_B;
      GntA    <= 1'b0;
      GntB    <= 1'b0;
      WrCount <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
    end else begin
      last <= last_next;
      GntA <= grant_a;
      GntB <= grant_b;
      if (grant_a || grant_b) begin
        WrCount <= WrCount + 8'd1;
      end
      // Addresses at or above DEPTH match no entry: granted, counted, dropped.
      for (int i = 0; i < DEPTH; i++) begin
        if ((grant_a || grant_b) && wr_addr == AW'(i)) begin
          bank[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    RdData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RdAddr == AW'(i)) begin
        RdData = bank[i];
      end
    end
  end

  grant_onehot : assert property (@(posedge Clk) disable iff (!Resetn)
    !(GntA && GntB));

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: reset, single writes, ties, sustained
// alternation, same-address collisions, out-of-range writes and mid-grant reset.
module tb_reg_bank_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 3;

  logic             clk;
  logic             rst_n;
  logic             req_a, req_b;
  logic [AW-1:0]    addr_a, addr_b, rd_addr;
  logic [WIDTH-1:0] data_a, data_b;
  logic             gnt_a, gnt_b;
  logic [WIDTH-1:0] rd_data;
  logic [7:0]       wr_count;

  int checks = 0;
  int errors = 0;

  reg_bank_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .Clk     (clk),
    .Resetn  (rst_n),
    .ReqA    (req_a),
    .AddrA   (addr_a),
    .DataA   (data_a),
    .GntA    (gnt_a),
    .ReqB    (req_b),
    .AddrB   (addr_b),
    .DataB   (data_b),
    .GntB    (gnt_b),
    .RdAddr  (rd_addr),
    .RdData  (rd_data),
    .WrCount (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input int addr, input logic [WIDTH-1:0] exp);
    rd_addr = AW'(addr);
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] exp_bank [DEPTH];

    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0; rd_addr = '0;

    // 1: reset state
    do_reset();
    check("rst_gnt_a", gnt_a, 1'b0);
    check("rst_gnt_b", gnt_b, 1'b0);
    check("rst_count", wr_count, 8'd0);
    for (int i = 0; i < 8; i++) rd_check($sformatf("rst_rd%0d", i), i, 8'h00);

    // 2: single write from A
    req_a = 1'b1; addr_a = 3'd2; data_a = 8'h5A; rd_addr = 3'd2;
    tick();
    req_a = 1'b0;
    check("single_gnt_a", gnt_a, 1'b1);
    check("single_gnt_b", gnt_b, 1'b0);
    check("single_count", wr_count, 8'd1);
    rd_check("single_rd2", 2, 8'h5A);
    tick();
    check("single_gnt_a_drop", gnt_a, 1'b0);

    // 3: tie after reset goes to A, then B
    do_reset();
    req_a = 1'b1; addr_a = 3'd0; data_a = 8'h11;
    req_b = 1'b1; addr_b = 3'd3; data_b = 8'h22;
    tick();
    check("tie_c1_gnt_a", gnt_a, 1'b1);
    check("tie_c1_gnt_b", gnt_b, 1'b0);
    req_a = 1'b0;
    tick();
    check("tie_c2_gnt_a", gnt_a, 1'b0);
    check("tie_c2_gnt_b", gnt_b, 1'b1);
    req_b = 1'b0;
    tick();
    check("tie_idle_gnt_a", gnt_a, 1'b0);
    check("tie_idle_gnt_b", gnt_b, 1'b0);
    check("tie_count", wr_count, 8'd2);
    rd_check("tie_rd0", 0, 8'h11);
    rd_check("tie_rd3", 3, 8'h22);

    // 4: both hold requests for 8 cycles -> strict A,B alternation
    do_reset();
    req_a = 1'b1; addr_a = 3'd0;
    req_b = 1'b1; addr_b = 3'd1;
    for (int i = 0; i < 8; i++) begin
      data_a = 8'(i);
      data_b = 8'(8'h80 + i);
      tick();
      check($sformatf("alt%0d_gnt_a", i), gnt_a, (i % 2) == 0);
      check($sformatf("alt%0d_gnt_b", i), gnt_b, (i % 2) == 1);
    end
    req_a = 1'b0; req_b = 1'b0;
    check("alt_count", wr_count, 8'd8);
    rd_check("alt_rd0", 0, 8'h06);
    rd_check("alt_rd1", 1, 8'h87);
    tick();
    check("alt_idle_gnt_a", gnt_a, 1'b0);
    check("alt_idle_gnt_b", gnt_b, 1'b0);

    // 5: same-address collision (Last=B, so A then B), then out-of-range write
    req_a = 1'b1; addr_a = 3'd1; data_a = 8'h11;
    req_b = 1'b1; addr_b = 3'd1; data_b = 8'h22;
    tick();
    check("coll_c1_gnt_a", gnt_a, 1'b1);
    rd_check("coll_c1_rd1", 1, 8'h11);
    req_a = 1'b0;
    tick();
    check("coll_c2_gnt_b", gnt_b, 1'b1);
    rd_check("coll_c2_rd1", 1, 8'h22);
    req_b = 1'b0;
    tick();
    check("coll_count", wr_count, 8'd10);
    exp_bank[0] = 8'h06; exp_bank[1] = 8'h22; exp_bank[2] = 8'h00; exp_bank[3] = 8'h00;
    req_a = 1'b1; addr_a = 3'd7; data_a = 8'hFF;
    tick();
    req_a = 1'b0;
    check("oor_gnt_a", gnt_a, 1'b1);
    check("oor_count", wr_count, 8'd11);
    for (int i = 0; i < DEPTH; i++) rd_check($sformatf("oor_rd%0d", i), i, exp_bank[i]);
    rd_check("oor_rd7", 7, 8'h00);
    rd_check("oor_rd5", 5, 8'h00);
    tick();

    // 6: asynchronous reset while GntA is high
    req_a = 1'b1; addr_a = 3'd2; data_a = 8'h33;
    tick();
    req_a = 1'b0;
    check("mid_gnt_a_before", gnt_a, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_gnt_a_async", gnt_a, 1'b0);
    check("mid_count_async", wr_count, 8'd0);
    for (int i = 0; i < DEPTH; i++) rd_check($sformatf("mid_rd%0d", i), i, 8'h00);
    rst_n = 1'b1;
    tick();
    req_a = 1'b1; addr_a = 3'd0; data_a = 8'h44;
    req_b = 1'b1; addr_b = 3'd1; data_b = 8'h55;
    tick();
    check("post_tie_gnt_a", gnt_a, 1'b1);
    check("post_tie_gnt_b", gnt_b, 1'b0);
    req_a = 1'b0;
    tick();
    check("post_tie_gnt_b2", gnt_b, 1'b1);
    req_b = 1'b0;
    tick();
    check("post_count", wr_count, 8'd2);
    rd_check("post_rd0", 0, 8'h44);
    rd_check("post_rd1", 1, 8'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
